// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register queue: opcodes, operand,
// result and stored-entry layouts.
package instr_register_pkg;

    localparam int OPW_DEFAULT = 32;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [OPW_DEFAULT-1:0]   operand_t;
    typedef logic signed [2*OPW_DEFAULT-1:0] result_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
        result_t  result;
        logic     div_err;
    } instruction_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational result unit: operands are sign-extended to double width
// before arithmetic; divide/modulo by zero yields 0 with div_err set.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
) (
    input  opcode_t                 opcode,
    input  logic signed [OPW-1:0]   a,
    input  logic signed [OPW-1:0]   b,
    output logic signed [2*OPW-1:0] result,
    output logic                    div_err
);

    logic signed [2*OPW-1:0] ax;
    logic signed [2*OPW-1:0] bx;
    logic                    b_zero;

    always_comb begin
        ax      = {{OPW{a[OPW-1]}}, a};
        bx      = {{OPW{b[OPW-1]}}, b};
        b_zero  = (b == '0);
        result  = '0;
        div_err = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = ax;
            PASSB: result = bx;
            ADD:   result = ax + bx;
            SUB:   result = ax - bx;
            MULT:  result = ax * bx;
            DIV: begin
                if (b_zero) div_err = 1'b1;
                else        result  = ax / bx;
            end
            MOD: begin
                if (b_zero) div_err = 1'b1;
                else        result  = ax % bx;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_queue.sv
// FIFO of computed instruction entries; result is evaluated at write time
// and the oldest entry is presented one cycle after a pop.
module instr_register_queue
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int OPW   = OPW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  opcode_t                opcode,
    input  logic signed [OPW-1:0]  operand_a,
    input  logic signed [OPW-1:0]  operand_b,
    input  logic                   read_en,
    output instruction_t           instruction_word,
    output logic                   valid_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          valid_q, valid_d;
    instruction_t  word_q, word_d;

    instruction_t  mem_q [DEPTH];
    instruction_t  new_entry;

    logic signed [2*OPW-1:0] alu_result;
    logic                    alu_div_err;
    logic                    do_wr;
    logic                    do_rd;

    instr_alu #(.OPW(OPW)) u_alu (
        .opcode  (opcode),
        .a       (operand_a),
        .b       (operand_b),
        .result  (alu_result),
        .div_err (alu_div_err)
    );

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        new_entry.opcode    = opcode;
        new_entry.operand_a = operand_t'(operand_a);
        new_entry.operand_b = operand_t'(operand_b);
        new_entry.result    = result_t'(alu_result);
        new_entry.div_err   = alu_div_err;
    end

    // A pop frees a slot in the same cycle, so a full queue still accepts.
    always_comb begin
        do_rd    = read_en && !empty;
        do_wr    = load_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
        ovf_d    = ovf_q || (load_en && full && !read_en);
        udf_d    = udf_q || (read_en && empty);
        valid_d  = do_rd;
        word_d   = do_rd ? mem_q[rd_ptr_q] : word_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            word_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            valid_q  <= valid_d;
            word_q   <= word_d;
        end
    end

    // Storage is not reset; stale slots are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= new_entry;
    end

    assign count            = count_q;
    assign overflow         = ovf_q;
    assign underflow        = udf_q;
    assign valid_out        = valid_q;
    assign instruction_word = word_q;

endmodule

// File: doc/instr_register_queue.md
INSTR_REGISTER_QUEUE -- requirements
Module: instr_register_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of instruction slots (power of 2, >=2).
REQ-002 SHALL have parameter OPW, default 32, signed operand width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port load_en  input  1  write request for opcode/operand_a/operand_b.
REQ-006 SHALL have port opcode  input  opcode_t  operation to store.
REQ-007 SHALL have ports operand_a, operand_b  input  OPW  signed operands.
REQ-008 SHALL have port read_en  input  1  pop request for oldest entry.
REQ-009 SHALL have port instruction_word  output  instruction_t  popped entry {opcode, operand_a, operand_b, result, div_err}.
REQ-010 SHALL have port valid_out  output  1  instruction_word holds a freshly popped entry this cycle.
REQ-011 SHALL have ports full, empty  output  1  occupancy status.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  entries stored.
REQ-013 SHALL have ports overflow, underflow  output  1  sticky error flags.

Function
REQ-014 Write: load_en=1 and not full -> entry stored at write pointer, pointer increments modulo DEPTH.
REQ-015 result SHALL be computed at write time, 2*OPW signed: ZERO->0, PASSA->a, PASSB->b, ADD->a+b, SUB->a-b, MULT->a*b, DIV->a/b, MOD->a%b (sign-extended before arithmetic).
REQ-016 DIV or MOD with operand_b=0 -> result 0, div_err=1; otherwise div_err=0.
REQ-017 Read: read_en=1 and not empty -> oldest entry driven on instruction_word next cycle with valid_out=1 for exactly one cycle; read pointer increments modulo DEPTH.
REQ-018 instruction_word SHALL hold its last value when no pop occurs; valid_out=0.
REQ-019 Write while full -> entry dropped, overflow set; read while empty -> no pop, valid_out=0, underflow set.
REQ-020 Simultaneous read+write when full -> both performed, count unchanged, overflow not set.
REQ-021 Simultaneous read+write when empty -> write performed only, underflow set, count becomes 1.
REQ-022 Simultaneous read+write otherwise -> both performed, count unchanged.
REQ-023 full = (count==DEPTH); empty = (count==0); both combinational from registered count.
REQ-024 Pointer wrap SHALL be seamless; order strictly FIFO across wrap.
REQ-025 overflow/underflow SHALL clear only on reset.

Reset
REQ-026 reset asserted SHALL immediately clear pointers, count, overflow, underflow, valid_out, and instruction_word to all zeros (opcode ZERO), regardless of clock.
REQ-027 Reset mid-operation discards all stored entries; storage array contents need not be cleared.
REQ-028 First write accepted on the first rising edge after reset deasserts.

Structure
REQ-029 opcode_t (3-bit enum ZERO..MOD), operand_t, result_t, instruction_t SHALL live in instr_register_pkg; OPW default constant also there.
REQ-030 Result computation SHALL be a combinational sub-module instr_alu (opcode, a, b -> result, div_err).
REQ-031 Storage SHALL be a DEPTH-entry array of instruction_t written by one always_ff block.

Verification
REQ-032 Reset, write ADD a=5 b=-3, pop -> instruction_word {ADD,5,-3,2,0}, valid_out=1 one cycle, empty=1.
REQ-033 Write DIV a=7 b=0 then MOD a=-7 b=2, pop twice -> results 0 (div_err=1) then -1 (div_err=0).
REQ-034 DEPTH=4: five writes -> full=1 after 4th, 5th dropped, overflow=1, pops return first four in order.
REQ-035 Pop when empty -> valid_out=0, underflow=1, count=0; simultaneous write same cycle -> count=1.
REQ-036 DEPTH=4 full, read+write same cycle 10 times -> count stays 4, FIFO order preserved across wrap, overflow=0.
REQ-037 Assert reset mid-stream with count=3 -> count=0, empty=1, flags=0, instruction_word=0 within same cycle.
